// File: rtl/parity_frame_tx_pkg.sv
// rtl/parity_frame_tx_pkg.sv - shared FSM encodings and elaboration helpers for parity_frame_tx
package parity_frame_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic bit stop_bits_legal(input int n);
      return (n == 1) || (n == 2);
   endfunction

   // ceil(log2(n)) but never below 1, so degenerate counters still get a bit
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/parity_frame_tx_tick.sv
// rtl/parity_frame_tx_tick.sv - bit-period timer; tick marks the last clk of each serial bit
module bit_tick_gen
   import parity_frame_tx_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int            TW   = clog2_min1(BIT_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

   logic [TW-1:0] timer_q, timer_d;

   always_comb begin
      timer_d = '0;
      if (en && (timer_q != LAST)) timer_d = timer_q + 1'b1;
   end

   assign tick = en && (timer_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - framed serialiser: start, data LSB-first, supplied parity, stop bits
module parity_frame_tx
   import parity_frame_tx_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int BIT_CYCLES = 4,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] stream,
   input  logic             parity,
   input  logic             valid,
   output logic             ready,
   output logic             tx,
   output logic             busy,
   output logic             par_err
);

   localparam int            IW        = clog2_min1(WIDTH + 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          ODD       = (PARITY_ODD != 0);

   generate
      if (!stop_bits_legal(STOP_BITS)) begin : g_stop_bits_check
         $error("parity_frame_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] shifted;
   logic [IW-1:0]    idx_q, idx_d;
   logic             par_q, par_d;
   logic             stop_q, stop_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             par_err_q, par_err_d;
   logic             accept;
   logic             tick_en;
   logic             tick;

   assign ready   = (state_q == ST_IDLE) && !rst;
   assign accept  = valid && ready;
   assign tick_en = (state_q != ST_IDLE);

   bit_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   // tx_d always carries the level of the bit that starts on the coming edge
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      par_d     = par_q;
      stop_d    = stop_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      par_err_d = 1'b0;
      shifted   = shift_q >> 1;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_START;
               shift_d   = stream;
               par_d     = parity;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               par_err_d = (parity != ((^stream) ^ ODD));
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_PARITY;
                  idx_d   = '0;
                  tx_d    = par_q;
               end else begin
                  shift_d = shifted;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shifted[0];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  stop_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         par_q     <= 1'b0;
         stop_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         par_err_q <= par_err_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign par_err = par_err_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - directed scoreboard bench for parity_frame_tx in three configurations
module tb_parity_frame_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] stream;
   logic       parity;
   logic [2:0] valid_v, ready_v, tx_v, busy_v, perr_v;

   int checks = 0;
   int errors = 0;

   // instance 0: defaults, 1: BIT_CYCLES=1/STOP_BITS=2, 2: PARITY_ODD=1
   int   bc_t[3] = '{4, 1, 4};
   int   sb_t[3] = '{1, 2, 1};
   logic exp_q[$];

   always #5 clk = ~clk;

   parity_frame_tx #(.WIDTH(10), .BIT_CYCLES(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst(rst), .stream(stream), .parity(parity), .valid(valid_v[0]),
      .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .par_err(perr_v[0]));

   parity_frame_tx #(.WIDTH(10), .BIT_CYCLES(1), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst(rst), .stream(stream), .parity(parity), .valid(valid_v[1]),
      .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .par_err(perr_v[1]));

   parity_frame_tx #(.WIDTH(10), .BIT_CYCLES(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
      .clk(clk), .rst(rst), .stream(stream), .parity(parity), .valid(valid_v[2]),
      .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .par_err(perr_v[2]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_level(input logic lvl, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(lvl);
   endtask

   task automatic push_frame(input int k, input logic [9:0] s, input logic p);
      push_level(1'b0, bc_t[k]);
      for (int b = 0; b < 10; b++) push_level(s[b], bc_t[k]);
      push_level(p, bc_t[k]);
      push_level(1'b1, sb_t[k] * bc_t[k]);
   endtask

   task automatic run_frame(input int k, input logic [9:0] s, input logic p, input logic exp_perr);
      int   n;
      logic e;
      @(negedge clk);
      stream     = s;
      parity     = p;
      valid_v[k] = 1'b1;
      chk("ready_before_accept", ready_v[k], 1'b1);
      push_frame(k, s, p);
      @(posedge clk);
      #1 valid_v[k] = 1'b0;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("tx_bit", tx_v[k], e);
         chk("busy_in_frame", busy_v[k], 1'b1);
         chk("par_err", perr_v[k], (i == 0) ? exp_perr : 1'b0);
         if (i == 0) chk("ready_in_frame", ready_v[k], 1'b0);
      end
      @(negedge clk);
      chk("tx_idle_after", tx_v[k], 1'b1);
      chk("busy_idle_after", busy_v[k], 1'b0);
      chk("ready_idle_after", ready_v[k], 1'b1);
   endtask

   initial begin
      logic e;
      rst     = 1'b1;
      valid_v = '0;
      stream  = '0;
      parity  = 1'b0;
      repeat (3) @(posedge clk);

      // reset state, plus rst winning over a simultaneous valid
      @(negedge clk);
      chk("rst_tx", tx_v[0], 1'b1);
      chk("rst_busy", busy_v[0], 1'b0);
      chk("rst_ready", ready_v[0], 1'b0);
      chk("rst_par_err", perr_v[0], 1'b0);
      stream     = 10'h155;
      parity     = 1'b1;
      valid_v[0] = 1'b1;
      @(negedge clk);
      chk("rst_valid_busy", busy_v[0], 1'b0);
      chk("rst_valid_tx", tx_v[0], 1'b1);
      chk("rst_valid_perr", perr_v[0], 1'b0);
      rst        = 1'b0;
      valid_v[0] = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", ready_v[0], 1'b1);
      chk("post_rst_busy", busy_v[0], 1'b0);

      // test 1 and 2: correct and corrupted parity
      run_frame(0, 10'h149, 1'b0, 1'b0);
      run_frame(0, 10'h149, 1'b1, 1'b1);

      // test 3: valid held, inputs change mid-frame, one idle cycle between frames
      @(negedge clk);
      stream     = 10'h3FF;
      parity     = 1'b0;
      valid_v[0] = 1'b1;
      chk("b2b_ready", ready_v[0], 1'b1);
      push_frame(0, 10'h3FF, 1'b0);
      exp_q.push_back(1'b1);
      push_frame(0, 10'h001, 1'b1);
      @(posedge clk);
      #1;
      stream = 10'h001;
      parity = 1'b1;
      for (int i = 1; i <= 105; i++) begin
         @(negedge clk);
         if (i == 54) valid_v[0] = 1'b0;
         e = exp_q.pop_front();
         chk("b2b_tx", tx_v[0], e);
         if (i == 53) begin
            chk("b2b_gap_ready", ready_v[0], 1'b1);
            chk("b2b_gap_busy", busy_v[0], 1'b0);
         end else begin
            chk("b2b_busy", busy_v[0], 1'b1);
         end
         if (i == 1 || i == 54) chk("b2b_par_err", perr_v[0], 1'b0);
      end
      @(negedge clk);
      chk("b2b_end_tx", tx_v[0], 1'b1);
      chk("b2b_end_busy", busy_v[0], 1'b0);

      // test 4: reset 20 cycles into a frame
      @(negedge clk);
      stream     = 10'h2C3;
      parity     = 1'b1;
      valid_v[0] = 1'b1;
      push_frame(0, 10'h2C3, 1'b1);
      @(posedge clk);
      #1 valid_v[0] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         chk("trunc_tx", tx_v[0], e);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("trunc_rst_tx", tx_v[0], 1'b1);
      chk("trunc_rst_busy", busy_v[0], 1'b0);
      chk("trunc_rst_ready", ready_v[0], 1'b0);
      chk("trunc_rst_perr", perr_v[0], 1'b0);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("trunc_ready", ready_v[0], 1'b1);
      chk("trunc_idle_tx", tx_v[0], 1'b1);
      run_frame(0, 10'h0A5, 1'b0, 1'b0);

      // test 5: one clk per bit, two stop bits
      run_frame(1, 10'h001, 1'b1, 1'b0);

      // test 6: odd parity expectation
      run_frame(2, 10'h000, 1'b0, 1'b1);
      run_frame(2, 10'h000, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
